// File: rtl/inst_encoder_pkg.sv
// Shared field formats, encoding constants and FSM state type for the RV32I instruction encoder.
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
`default_nettype none

package inst_encoder_pkg;

  localparam int XLEN         = 32;
  localparam int OPCODE_WIDTH = 7;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -(1 << 20);
  localparam int IMM_J_MAX = (1 << 20) - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic in_range(input logic [XLEN-1:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_encoder_pack.sv
// inst_pack: combinational packing of instruction fields into an RV32I word.
// With IMM_CHECK_EN defined, out-of-range immediates and unknown formats yield NOP plus err.
`default_nettype none

module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [2:0]              fmt,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [XLEN-1:0]         imm,
  output logic [XLEN-1:0]         inst,
  output logic                    err
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = INST_NOP;
    case (fmt)
      FMT_R:   raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   raw = {imm[31:12], rd, opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = INST_NOP;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic imm_bad;
  logic bad_fmt;

  assign bad_fmt = (fmt > FMT_J);

  always_comb begin
    imm_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: imm_bad = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
      FMT_B:        imm_bad = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
      FMT_J:        imm_bad = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
      FMT_U:        imm_bad = |imm[11:0];
      default:      imm_bad = 1'b0;
    endcase
  end

  assign err  = bad_fmt || imm_bad;
  assign inst = err ? INST_NOP : raw;
`else
  // Without checking, immediates are truncated to the format's field bits.
  assign err  = 1'b0;
  assign inst = raw;
`endif

endmodule

`default_nettype wire

// File: rtl/inst_encoder.sv
// inst_encoder: streams packed RV32I words with byte addresses into instruction memory in bounded bursts.
// Immediate range checking in inst_pack is enabled by defining IMM_CHECK_EN.
`default_nettype none

module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [XLEN-1:0]         start_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_fmt,
  input  logic [OPCODE_WIDTH-1:0] in_opcode,
  input  logic [4:0]              in_rd,
  input  logic [4:0]              in_rs1,
  input  logic [4:0]              in_rs2,
  input  logic [2:0]              in_funct3,
  input  logic [6:0]              in_funct7,
  input  logic [XLEN-1:0]         in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_addr,
  output logic [XLEN-1:0]         out_inst,
  output logic                    out_err,
  output logic                    done,
  output logic [CNT_W-1:0]        count
);

  localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_WORDS);
  localparam logic [CNT_W:0] ONE     = (CNT_W + 1)'(1);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] next_addr;
  logic [XLEN-1:0] pack_inst;
  logic            pack_err;
  logic            load;
  logic            drain;
  logic            last_drain;
  logic            start_ok;
  logic            room;

  inst_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  assign load       = in_valid && in_ready;
  assign drain      = out_valid && out_ready;
  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  // The word sitting in the output register already counts against the burst limit.
  assign room       = ({1'b0, count} + {{CNT_W{1'b0}}, out_valid}) < MAX_CNT;
  assign last_drain = drain && (({1'b0, count} + ONE) == MAX_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_drain) state_next = ST_DONE;
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_RUN) && (!out_valid || out_ready) && room;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_inst  <= '0;
      out_err   <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      next_addr <= '0;
    end else begin
      done <= last_drain;
      if (start_ok) begin
        next_addr <= start_addr & ~32'd3;
        count     <= '0;
      end else begin
        if (drain) count <= count + 1'b1;
        if (load)  next_addr <= next_addr + 32'd4;
      end
      if (load) begin
        out_valid <= 1'b1;
        out_inst  <= pack_inst;
        out_err   <= pack_err;
        out_addr  <= next_addr;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encodings, randomized bursts against a field-level model.
// Expected values follow IMM_CHECK_EN when the macro is defined for the build.
`default_nettype none

module tb_inst_encoder;

  localparam int MAXW = 4;
  localparam int CW   = 3;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   start_addr = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_addr;
  logic [31:0]   out_inst;
  logic          out_err;
  logic          done;
  logic [CW-1:0] count;

  int passed = 0;
  int total  = 0;

  bundle_t     stim[$];
  logic [31:0] obs_inst[$];
  logic [31:0] obs_addr[$];
  logic        obs_err[$];

  inst_encoder #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_inst(out_inst), .out_err(out_err), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.op = op; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
    return b;
  endfunction

  // Field placement written as shifts and masks of the architectural immediate value.
  function automatic void model(input bundle_t b, output logic [31:0] inst, output logic err);
    logic [31:0] i;
    logic [31:0] rdp;
    logic [31:0] low;
    int          s;
    i   = b.imm;
    s   = $signed(b.imm);
    rdp = 32'(b.rd) << 7;
    low = (32'(b.rs1) << 15) | (32'(b.f3) << 12) | 32'(b.op);
    err = 1'b0;
    case (b.fmt)
      3'd0: inst = (32'(b.f7) << 25) | (32'(b.rs2) << 20) | low | rdp;
      3'd1: inst = ((i & 32'hFFF) << 20) | low | rdp;
      3'd2: inst = (((i >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | low | ((i & 32'h1F) << 7);
      3'd3: inst = (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | (32'(b.rs2) << 20) | low
                   | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
      3'd4: inst = (i & 32'hFFFF_F000) | rdp | 32'(b.op);
      3'd5: inst = (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) | (((i >> 11) & 1) << 20)
                   | (((i >> 12) & 32'hFF) << 12) | rdp | 32'(b.op);
      default: begin
        inst = 32'h0000_0013;
`ifdef IMM_CHECK_EN
        err = 1'b1;
`endif
      end
    endcase
`ifdef IMM_CHECK_EN
    case (b.fmt)
      3'd1, 3'd2: if (s < -2048 || s > 2047) err = 1'b1;
      3'd3:       if (s < -4096 || s > 4094 || (s % 2) != 0) err = 1'b1;
      3'd4:       if ((i % 4096) != 0) err = 1'b1;
      3'd5:       if (s < -1048576 || s > 1048574 || (s % 2) != 0) err = 1'b1;
      default:    ;
    endcase
    if (err) inst = 32'h0000_0013;
`else
    if (s == 32'h7fff_ffff) err = 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_imm();
    int r;
    r = $urandom_range(0, 4);
    case (r)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      3:       return $urandom & 32'hFFFF_F000;
      default: return 32'($urandom_range(0, 4095)) - 32'd2048;
    endcase
  endfunction

  function automatic bundle_t rand_bundle();
    return mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), rand_imm());
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bundle_t b);
    in_fmt = b.fmt; in_opcode = b.op; in_rd = b.rd; in_rs1 = b.rs1; in_rs2 = b.rs2;
    in_funct3 = b.f3; in_funct7 = b.f7; in_imm = b.imm;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_addr !== 32'h0) $display("FAIL reset_out_addr: got %h want 0", out_addr); else passed++;
    total++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst: got %h want 0", out_inst); else passed++;
    total++; if (out_err !== 1'b0) $display("FAIL reset_out_err: got %b want 0", out_err); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    rst = 1'b1;
    tick();
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL idle_in_ready: got %b want 0", in_ready); else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  // One full burst of MAXW words from stim; mode 0 ready=1, 1 ready toggles, 2 random valid/ready/start.
  task automatic test_stream(input string name, input logic [31:0] base, input int mode);
    logic [31:0] eq_inst[$];
    logic [31:0] eq_addr[$];
    logic        eq_err[$];
    logic [31:0] mi;
    logic        me;
    logic        exp_ir;
    int          sent;
    int          drained;
    sent = 0;
    drained = 0;
    obs_inst.delete(); obs_addr.delete(); obs_err.delete();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL %s_pre_start_in_ready: got %b want 0", name, in_ready); else passed++;
    start = 1'b1;
    start_addr = base;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && drained < MAXW; cyc++) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      in_valid = (sent < MAXW) && (mode != 2 || $urandom_range(0, 3) != 0);
      drive((sent < MAXW) ? stim[sent] : rand_bundle());
      start = (mode == 2) && ($urandom_range(0, 7) == 0);
      start_addr = $urandom;
      #1;
      exp_ir = (eq_inst.size() == 0 || out_ready) && (sent < MAXW);
      total++; if (in_ready !== exp_ir) $display("FAIL %s_in_ready: cyc %0d got %b want %b", name, cyc, in_ready, exp_ir); else passed++;
      total++; if (out_valid !== (eq_inst.size() != 0)) $display("FAIL %s_out_valid: cyc %0d got %b want %b", name, cyc, out_valid, eq_inst.size() != 0); else passed++;
      total++; if (count !== CW'(drained)) $display("FAIL %s_count: cyc %0d got %0d want %0d", name, cyc, count, drained); else passed++;
      total++; if (done !== 1'b0) $display("FAIL %s_done_early: cyc %0d got %b want 0", name, cyc, done); else passed++;
      if (out_valid && out_ready && eq_inst.size() != 0) begin
        total++; if (out_inst !== eq_inst[0]) $display("FAIL %s_inst: word %0d got %h want %h", name, drained, out_inst, eq_inst[0]); else passed++;
        total++; if (out_addr !== eq_addr[0]) $display("FAIL %s_addr: word %0d got %h want %h", name, drained, out_addr, eq_addr[0]); else passed++;
        total++; if (out_err !== eq_err[0]) $display("FAIL %s_err: word %0d got %b want %b", name, drained, out_err, eq_err[0]); else passed++;
        obs_inst.push_back(out_inst); obs_addr.push_back(out_addr); obs_err.push_back(out_err);
        void'(eq_inst.pop_front()); void'(eq_addr.pop_front()); void'(eq_err.pop_front());
        drained++;
      end
      if (in_valid && in_ready && sent < MAXW) begin
        model(stim[sent], mi, me);
        eq_inst.push_back(mi);
        eq_err.push_back(me);
        eq_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * sent));
        sent++;
      end
      tick();
    end
    start = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    total++; if (drained != MAXW) $display("FAIL %s_timeout: drained %0d want %0d", name, drained, MAXW); else passed++;
    total++; if (done !== 1'b1) $display("FAIL %s_done_pulse: got %b want 1", name, done); else passed++;
    total++; if (count !== CW'(MAXW)) $display("FAIL %s_final_count: got %0d want %0d", name, count, MAXW); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL %s_stall_in_ready: got %b want 0", name, in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL %s_final_out_valid: got %b want 0", name, out_valid); else passed++;
    tick();
    #1;
    total++; if (done !== 1'b0) $display("FAIL %s_done_once: got %b want 0", name, done); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL %s_done_in_ready: got %b want 0", name, in_ready); else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_spec_vectors();
    logic [31:0] want_i2048;
    logic [31:0] want_b3;
    logic        want_e;
`ifdef IMM_CHECK_EN
    want_i2048 = 32'h0000_0013; want_b3 = 32'h0000_0013; want_e = 1'b1;
`else
    want_i2048 = 32'h8000_0093; want_b3 = 32'h0000_0163; want_e = 1'b0;
`endif
    stim.delete();
    stim.push_back(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    stim.push_back(mk(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8));
    stim.push_back(mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4));
    stim.push_back(mk(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800));
    test_stream("spec1", 32'h100, 0);
    total++; if (obs_inst[0] !== 32'h0050_0093) $display("FAIL vec_I: got %h want 00500093", obs_inst[0]); else passed++;
    total++; if (obs_addr[0] !== 32'h100) $display("FAIL vec_I_addr: got %h want 00000100", obs_addr[0]); else passed++;
    total++; if (obs_err[0] !== 1'b0) $display("FAIL vec_I_err: got %b want 0", obs_err[0]); else passed++;
    total++; if (obs_inst[1] !== 32'h0020_A423) $display("FAIL vec_S: got %h want 0020a423", obs_inst[1]); else passed++;
    total++; if (obs_addr[1] !== 32'h104) $display("FAIL vec_S_addr: got %h want 00000104", obs_addr[1]); else passed++;
    total++; if (obs_inst[2] !== 32'hFE00_0EE3) $display("FAIL vec_B: got %h want fe000ee3", obs_inst[2]); else passed++;
    total++; if (obs_addr[2] !== 32'h108) $display("FAIL vec_B_addr: got %h want 00000108", obs_addr[2]); else passed++;
    total++; if (obs_inst[3] !== 32'h0010_00EF) $display("FAIL vec_J: got %h want 001000ef", obs_inst[3]); else passed++;
    stim.delete();
    stim.push_back(mk(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000));
    stim.push_back(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048));
    stim.push_back(mk(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3));
    stim.push_back(mk(3'd7, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
    test_stream("spec2", 32'h203, 0);
    total++; if (obs_inst[0] !== 32'h1234_52B7) $display("FAIL vec_U: got %h want 123452b7", obs_inst[0]); else passed++;
    total++; if (obs_addr[0] !== 32'h200) $display("FAIL vec_U_addr: got %h want 00000200", obs_addr[0]); else passed++;
    total++; if (obs_inst[1] !== want_i2048) $display("FAIL vec_I2048: got %h want %h", obs_inst[1], want_i2048); else passed++;
    total++; if (obs_err[1] !== want_e) $display("FAIL vec_I2048_err: got %b want %b", obs_err[1], want_e); else passed++;
    total++; if (obs_inst[2] !== want_b3) $display("FAIL vec_B3: got %h want %h", obs_inst[2], want_b3); else passed++;
    total++; if (obs_err[2] !== want_e) $display("FAIL vec_B3_err: got %b want %b", obs_err[2], want_e); else passed++;
    total++; if (obs_inst[3] !== 32'h0000_0013) $display("FAIL vec_badfmt: got %h want 00000013", obs_inst[3]); else passed++;
  endtask

  task automatic test_toggle_ready_wrap();
    stim.delete();
    for (int k = 0; k < MAXW; k++) stim.push_back(rand_bundle());
    test_stream("wrap", 32'hFFFF_FFFE, 1);
    total++; if (obs_addr[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", obs_addr[0]); else passed++;
    total++; if (obs_addr[1] !== 32'h0) $display("FAIL wrap_addr1: got %h want 00000000", obs_addr[1]); else passed++;
  endtask

  task automatic test_random_bursts();
    for (int n = 0; n < 10; n++) begin
      stim.delete();
      for (int k = 0; k < MAXW; k++) stim.push_back(rand_bundle());
      test_stream("rand", $urandom, 2);
    end
  endtask

  task automatic test_midburst_reset();
    out_ready = 1'b0;
    start = 1'b1;
    start_addr = 32'h40;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    drive(mk(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5));
    tick();
    in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL mid_loaded: got %b want 1", out_valid); else passed++;
    rst = 1'b0;
    tick();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_inst !== 32'h0) $display("FAIL mid_rst_out_inst: got %h want 0", out_inst); else passed++;
    total++; if (out_addr !== 32'h0) $display("FAIL mid_rst_out_addr: got %h want 0", out_addr); else passed++;
    total++; if (count !== '0) $display("FAIL mid_rst_count: got %0d want 0", count); else passed++;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL mid_idle_in_ready: cyc %0d got %b want 0", k, in_ready); else passed++;
      total++; if (done !== 1'b0) $display("FAIL mid_no_done: cyc %0d got %b want 0", k, done); else passed++;
      tick();
    end
    in_valid = 1'b0;
    start = 1'b1;
    start_addr = 32'h80;
    tick();
    start = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_restart_in_ready: got %b want 1", in_ready); else passed++;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_toggle_ready_wrap();
    test_random_bursts();
    test_midburst_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
